cmd_fetch: RTL
==============

Name: cmd_fetch

Overview:
Fetch sequencer for the core. It owns the program counter and drives the request/address side of the command memory (in_cmd_mem/adr_cmd). It captures each returned 32-bit command, resolves unconditional jumps internally, and hands every other command to the downstream decoder over a valid/ready handshake.

Parameters:
ADDR_W, 4, width of command-memory address and PC
MEM_DEPTH, 5, number of valid command words; legal PC range 0..MEM_DEPTH-1
RESET_PC, 0, PC value loaded on reset

Ports:
clk  in  1  core clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
run  in  1  fetch enable; low = stop issuing new requests
in_cmd_mem  out  1  command-memory request strobe
adr_cmd  out  ADDR_W  command-memory address
out_cmd_mem  in  1  command-memory data-valid flag
cmd  in  32  command word from memory
instr  out  32  command forwarded to decoder
instr_pc  out  ADDR_W  address the forwarded command was fetched from
instr_valid  out  1  instr/instr_pc valid
instr_ready  in  1  decoder accepts instr
pc  out  ADDR_W  current program counter
fetch_err  out  1  sticky: jump target out of range

Behaviour:
- Reset (async, rst=1): state=IDLE; pc=RESET_PC; in_cmd_mem=0; adr_cmd=0; instr=0; instr_pc=0; instr_valid=0; fetch_err=0.
- Command format: [31:26] opcode, [25:21],[20:16],[15:11],[10:6] fields, [5:0] funct/imm. Opcode 6'b111111 = JMP, target = cmd[ADDR_W-1:0].
- Memory contract: the memory registers cmd and raises out_cmd_mem one cycle after it samples in_cmd_mem=1; out_cmd_mem falls one cycle after in_cmd_mem=0. The fetch unit pulses in_cmd_mem for exactly one cycle per fetch.
- FSM states: IDLE, REQ, WAIT, HOLD.
- IDLE: in_cmd_mem=0. If run=1, go to REQ.
- REQ: in_cmd_mem=1, adr_cmd=pc, for one cycle. Always go to WAIT.
- WAIT: in_cmd_mem=0. Stay in WAIT while out_cmd_mem=0 (no timeout). When out_cmd_mem=1, sample cmd:
  - Non-JMP: instr<=cmd, instr_pc<=pc, instr_valid<=1, pc<=next(pc), go to HOLD.
  - JMP with target<MEM_DEPTH: pc<=target, not forwarded; go to REQ if run=1, else IDLE.
  - JMP with target>=MEM_DEPTH: pc<=0, fetch_err<=1; then as for a legal JMP.
- HOLD: instr_valid=1, instr and instr_pc stable. When instr_ready=1: instr_valid<=0; go to REQ if run=1, else IDLE. instr_ready=0 holds indefinitely.
- next(pc) = pc+1, wrapping to 0 when pc==MEM_DEPTH-1.
- Latency: 3 cycles from REQ to instr_valid. Throughput with instr_ready tied high is one command per 3 cycles; a JMP costs 2 cycles and produces no output.
- run deassert: never aborts an outstanding fetch or a held instr. It only blocks the transition into REQ.
- instr_ready while instr_valid=0: ignored.
- Reset mid-WAIT or mid-HOLD: everything returns to reset values immediately. A late out_cmd_mem pulse after reset is ignored, because the FSM is in IDLE.
- fetch_err clears only on rst.

Decomposition:
- Shared package core_pkg: OPC_W=6, OPC_JMP=6'b111111, field bit-position constants, typedef cmd_t (packed struct: opcode, r1, r2, r3, r4, funct), typedef enum fetch_state_t.
- One sub-module, cmd_fetch_pc: combinational next-PC and jump-range check (inputs pc, is_jmp, target; outputs pc_next, range_err).

Test Plan:
- Reset release with run=1, instr_ready=1, memory {0x00200030, 0x00200031, 0x04600003, 0x04800004, 0xFC000001} -> instr sequence 0x00200030 (pc0), 0x00200031 (pc1), 0x04600003 (pc2), 0x04800004 (pc3). The JMP at pc4 is not forwarded; the next instr is 0x00200031 at pc1. First instr_valid appears 3 cycles after the first REQ.
- instr_ready held 0 for 10 cycles at pc2 -> instr_valid stays 1, instr=0x04600003, no in_cmd_mem pulse. Releasing ready gives one accept, then REQ with adr_cmd=3.
- run dropped during WAIT at pc1 -> 0x00200031 is still delivered, then FSM goes to IDLE with pc=2 and no further requests. Raising run resumes with adr_cmd=2.
- Word 4 replaced by 0xFC00000A (target 10 >= 5) -> fetch_err=1, next adr_cmd=0; fetch_err stays 1 until rst.
- MEM_DEPTH=5 with no JMP (word 4 = 0x00200030) -> after pc=4 the next adr_cmd=0 (wrap).
- rst asserted in WAIT with out_cmd_mem arriving the following cycle -> all outputs at reset values, instr_valid never rises, and the first post-reset REQ uses adr_cmd=RESET_PC=0.

Source files
------------

// File: rtl/core_pkg.sv
// Shared command-format definitions and fetch FSM state type.
package core_pkg;

  localparam int OPC_W     = 6;
  localparam logic [OPC_W-1:0] OPC_JMP = 6'b111111;

  // Field LSB positions inside a 32-bit command word
  localparam int OPC_LSB   = 26;
  localparam int R1_LSB    = 21;
  localparam int R2_LSB    = 16;
  localparam int R3_LSB    = 11;
  localparam int R4_LSB    = 6;
  localparam int FUNCT_LSB = 0;

  typedef struct packed {
    logic [5:0] opcode;
    logic [4:0] r1;
    logic [4:0] r2;
    logic [4:0] r3;
    logic [4:0] r4;
    logic [5:0] funct;
  } cmd_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/cmd_fetch_pc.sv
// Next-PC selection: sequential increment with wrap, or jump target,
// with out-of-range jumps redirected to 0 and flagged.
module cmd_fetch_pc #(
  parameter int ADDR_W    = 4,
  parameter int MEM_DEPTH = 5
) (
  input  logic [ADDR_W-1:0] pc,
  input  logic              is_jmp,
  input  logic [ADDR_W-1:0] target,
  output logic [ADDR_W-1:0] pc_next,
  output logic              range_err
);

  // One extra bit so MEM_DEPTH == 2**ADDR_W still compares correctly
  localparam logic [ADDR_W:0]   DEPTH = (ADDR_W+1)'(MEM_DEPTH);
  localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(MEM_DEPTH - 1);

  // Combinational next-PC and jump range check
  always_comb begin
    range_err = is_jmp && ({1'b0, target} >= DEPTH);
    pc_next   = '0;
    if (is_jmp)
      pc_next = range_err ? '0 : target;
    else if (pc == LAST)
      pc_next = '0;
    else
      pc_next = pc + 1'b1;
  end

endmodule

// File: rtl/cmd_fetch.sv
// Command fetch sequencer: owns the PC, issues single-cycle memory
// requests, resolves JMP internally, forwards everything else downstream.
module cmd_fetch
  import core_pkg::*;
#(
  parameter int ADDR_W    = 4,
  parameter int MEM_DEPTH = 5,
  parameter int RESET_PC  = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  output logic              in_cmd_mem,
  output logic [ADDR_W-1:0] adr_cmd,
  input  logic              out_cmd_mem,
  input  logic [31:0]       cmd,
  output logic [31:0]       instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [ADDR_W-1:0] pc,
  output logic              fetch_err
);

  localparam logic [ADDR_W-1:0] PC_RST = ADDR_W'(RESET_PC);

  fetch_state_t      state;
  logic              is_jmp;
  logic [ADDR_W-1:0] target;
  logic [ADDR_W-1:0] pc_next;
  logic              range_err;

  assign is_jmp = (cmd[OPC_LSB +: OPC_W] == OPC_JMP);
  assign target = cmd[ADDR_W-1:0];

  cmd_fetch_pc #(
    .ADDR_W    (ADDR_W),
    .MEM_DEPTH (MEM_DEPTH)
  ) u_pc (
    .pc        (pc),
    .is_jmp    (is_jmp),
    .target    (target),
    .pc_next   (pc_next),
    .range_err (range_err)
  );

  // Fetch FSM; in_cmd_mem/adr_cmd are loaded on the edge that enters REQ,
  // so the request strobe is high for exactly the REQ cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      pc          <= PC_RST;
      in_cmd_mem  <= 1'b0;
      adr_cmd     <= '0;
      instr       <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
      fetch_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (run) begin
            state      <= REQ;
            in_cmd_mem <= 1'b1;
            adr_cmd    <= pc;
          end
        end
        REQ: begin
          state      <= WAIT;
          in_cmd_mem <= 1'b0;
        end
        WAIT: begin
          if (out_cmd_mem) begin
            pc <= pc_next;
            if (!is_jmp) begin
              instr       <= cmd;
              instr_pc    <= pc;
              instr_valid <= 1'b1;
              state       <= HOLD;
            end else begin
              if (range_err) fetch_err <= 1'b1;
              // Jump retargets straight into the next request
              if (run) begin
                state      <= REQ;
                in_cmd_mem <= 1'b1;
                adr_cmd    <= pc_next;
              end else begin
                state <= IDLE;
              end
            end
          end
        end
        HOLD: begin
          if (instr_ready) begin
            instr_valid <= 1'b0;
            if (run) begin
              state      <= REQ;
              in_cmd_mem <= 1'b1;
              adr_cmd    <= pc;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
